// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types: architectural register count and physical register index.
package phys_free_list_pkg;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned PREG_BITS = 6;
    localparam int unsigned NUM_PREGS = 64;

    typedef logic [PREG_BITS-1:0] phys_reg_t;

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical registers for rename: one grant and one reclaim per
// cycle, with single-cycle restore of all speculatively granted registers on flush.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int unsigned PHYS_REG_BITS = PREG_BITS,
    parameter int unsigned NUM_PHYS      = NUM_PREGS
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          dequeue,
    input  logic                                          enqueue,
    input  logic [PHYS_REG_BITS-1:0]                      enq_pd,
    input  logic                                          flush,
    output logic [PHYS_REG_BITS-1:0]                      free_pd,
    output logic                                          empty,
    output logic                                          full,
    output logic [$clog2(NUM_PHYS-ARCH_REGS):0]           free_count
);

    localparam int unsigned DEPTH    = NUM_PHYS - ARCH_REGS;
    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    // Pointer MSB is the wrap bit; DEPTH is a power of two so a plain add wraps correctly.
    function automatic logic [PTR_BITS:0] ptr_inc(input logic [PTR_BITS:0] p);
        return p + (PTR_BITS+1)'(1);
    endfunction

    logic [PHYS_REG_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS:0]        head_q, head_d;
    logic [PTR_BITS:0]        tail_q, tail_d;
    logic                     do_deq;
    logic                     do_enq;

    assign empty      = (head_q == tail_q);
    assign full       = (head_q[PTR_BITS-1:0] == tail_q[PTR_BITS-1:0]) &&
                        (head_q[PTR_BITS] != tail_q[PTR_BITS]);
    assign free_count = CNT_BITS'(tail_q - head_q);
    assign free_pd    = mem[head_q[PTR_BITS-1:0]];

    // Flush re-exposes every slot: head lands one lap behind the post-enqueue tail.
    always_comb begin
        do_deq = dequeue && !empty && !flush;
        do_enq = enqueue && (enq_pd != '0) && !full;
        tail_d = do_enq ? ptr_inc(tail_q) : tail_q;
        head_d = head_q;
        if (flush) begin
            head_d = {~tail_d[PTR_BITS], tail_d[PTR_BITS-1:0]};
        end else if (do_deq) begin
            head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= {1'b1, PTR_BITS'(0)};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (do_enq) begin
                mem[tail_q[PTR_BITS-1:0]] <= enq_pd;
            end
        end
    end

    // p0 is hardwired zero and must never be handed out as a destination.
    logic                p0_live;
    logic [PTR_BITS-1:0] slot_off;
    always_comb begin
        p0_live  = 1'b0;
        slot_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_off = PTR_BITS'(i) - head_q[PTR_BITS-1:0];
            if ((CNT_BITS'(slot_off) < free_count) && (mem[i] == '0)) begin
                p0_live = 1'b1;
            end
        end
    end

    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(dequeue && empty))
        else $warning("phys_free_list: dequeue while empty ignored");
    a_no_enq_full: assert property (@(posedge clk) disable iff (rst) !(enqueue && full))
        else $warning("phys_free_list: enqueue while full dropped");
    a_no_p0_live: assert property (@(posedge clk) disable iff (rst) !p0_live)
        else $error("phys_free_list: p0 present in free region");

endmodule

// File: tb/tb_phys_free_list.sv
// Randomized and directed bench for phys_free_list against a queue-based reference model.
module tb_phys_free_list;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dequeue = 1'b0;
    logic       enqueue = 1'b0;
    logic [5:0] enq_pd = '0;
    logic       flush = 1'b0;
    logic [5:0] free_pd;
    logic       empty;
    logic       full;
    logic [5:0] free_count;

    int checks = 0;
    int errors = 0;

    // Model: free_q is the free list in grant order; hist holds the last DEPTH values
    // written into the ring, which is exactly the list after a flush.
    int free_q[$];
    int hist[$];

    phys_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .dequeue    (dequeue),
        .enqueue    (enqueue),
        .enq_pd     (enq_pd),
        .flush      (flush),
        .free_pd    (free_pd),
        .empty      (empty),
        .full       (full),
        .free_count (free_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) begin
            free_q.push_back(32 + i);
            hist.push_back(32 + i);
        end
    endtask

    task automatic model_step(input bit deq, input bit enq, input int pd, input bit fl);
        int  sz;
        bit  enq_ok;
        bit  deq_ok;
        int  dummy;
        sz     = free_q.size();
        enq_ok = enq && (pd != 0) && (sz < DEPTH);
        deq_ok = deq && (sz > 0) && !fl;
        if (deq_ok) dummy = free_q.pop_front();
        if (enq_ok) begin
            free_q.push_back(pd);
            hist.push_back(pd);
            if (hist.size() > DEPTH) dummy = hist.pop_front();
        end
        if (fl) free_q = hist;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = free_q.size();
        check({tag, "_count"}, int'(free_count), sz);
        check({tag, "_empty"}, int'(empty), int'(sz == 0));
        check({tag, "_full"},  int'(full),  int'(sz == DEPTH));
        if (sz != 0) check({tag, "_pd"}, int'(free_pd), free_q[0]);
    endtask

    // Apply one cycle of inputs (called just after a negedge), update model, check at next negedge.
    task automatic cycle(input bit deq, input bit enq, input int pd, input bit fl, input string tag);
        dequeue = deq;
        enqueue = enq;
        enq_pd  = 6'(pd);
        flush   = fl;
        @(posedge clk);
        model_step(deq, enq, pd, fl);
        @(negedge clk);
        dequeue = 1'b0;
        enqueue = 1'b0;
        enq_pd  = '0;
        flush   = 1'b0;
        check_model(tag);
    endtask

    // Raise rst between edges and expect reset values before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_pd",    int'(free_pd), 32);
        check("rst_full",  int'(full), 1);
        check("rst_empty", int'(empty), 0);
        check("rst_count", int'(free_count), 32);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dequeue = 1'b0;
        enqueue = 1'b0;
        enq_pd  = '0;
        flush   = 1'b0;
    endtask

    initial begin
        int got[$];
        int exp_seq[$];
        int n7;
        int n9;

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: reset state then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check("t1_grant", int'(free_pd), 32 + i);
            cycle(1, 0, 0, 0, "t1");
        end
        check("t1_empty", int'(empty), 1);
        check("t1_zero",  int'(free_count), 0);

        // 2: dequeue+enqueue while empty: enqueue lands, no grant
        cycle(1, 1, 5, 0, "t2");
        check("t2_pd",    int'(free_pd), 5);
        check("t2_count", int'(free_count), 1);

        // 3: three grants then flush restores them
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("t3_grant", int'(free_pd), 32 + i);
            cycle(1, 0, 0, 0, "t3");
        end
        cycle(0, 0, 0, 1, "t3f");
        check("t3_full",  int'(full), 1);
        check("t3_pd",    int'(free_pd), 32);
        check("t3_count", int'(free_count), 32);

        // 4: commits reclaim 7 and 9, flush alongside the second
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, "t4d");
        cycle(0, 1, 7, 0, "t4e");
        cycle(0, 1, 9, 1, "t4f");
        check("t4_full",  int'(full), 1);
        check("t4_count", int'(free_count), 32);
        got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            got.push_back(int'(free_pd));
            cycle(1, 0, 0, 0, "t4r");
        end
        exp_seq.delete();
        for (int k = 0; k < 30; k++) exp_seq.push_back(34 + k);
        exp_seq.push_back(7);
        exp_seq.push_back(9);
        n7 = 0;
        n9 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            check("t4_seq", got[i], exp_seq[i]);
            if (got[i] == 7) n7++;
            if (got[i] == 9) n9++;
        end
        check("t4_once7", n7, 1);
        check("t4_once9", n9, 1);

        // 5: p0 reclaim dropped; enqueue while full dropped
        do_reset();
        cycle(1, 0, 0, 0, "t5d");
        cycle(0, 1, 0, 0, "t5z");
        check("t5_p0_count", int'(free_count), 31);
        cycle(0, 1, 12, 0, "t5e");
        cycle(0, 1, 20, 0, "t5x");
        check("t5_full_count", int'(free_count), 32);
        check("t5_full_pd",    int'(free_pd), 33);

        // 6: random traffic, with async reset mid-burst
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            bit d;
            bit e;
            bit f;
            int p;
            if (c == 5000) do_reset();
            d = ($urandom_range(0, 1) == 1) && (free_q.size() > 0);
            e = ($urandom_range(0, 1) == 1) && (free_q.size() < DEPTH);
            p = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 63));
            f = ($urandom_range(0, 63) == 0);
            cycle(d, e, p, f, "t6");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
